// File: rtl/rs_multi_cdb_pkg.sv
// rs_multi_cdb_pkg: default widths, the "no dependency" nick and op encodings shared by the RS slice.
package rs_multi_cdb_pkg;
  localparam int NICK_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;
  localparam int ADDR_W_DEF = 32;
  localparam int IMM_W_DEF  = 32;
  localparam logic [NICK_W_DEF-1:0] NICK_READY = '0;
  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD = 6'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_BEQ, OP_BNE, OP_JAL
  } op_e;
endpackage

// File: rtl/rs_multi_cdb_age_sel.sv
// rs_age_sel: picks one ready RS entry, one-hot. With RS_AGE_PRIO_EN an age matrix selects the oldest
// ready entry; otherwise the lowest-index ready entry wins.
module rs_age_sel #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] occ_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] gnt_o
);
`ifdef RS_AGE_PRIO_EN
  // older_q[j][i] = entry j was allocated before entry i
  logic [DEPTH-1:0] older_q [DEPTH];
  logic             blk;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    else if (rdy)
      for (int n = 0; n < DEPTH; n++)
        if (alloc_i[n]) begin
          older_q[n] <= '0;
          for (int i = 0; i < DEPTH; i++) older_q[i][n] <= occ_i[i];
        end
  always_comb begin
    gnt_o = '0;
    blk   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++) blk = blk | (req_i[j] & older_q[j][i]);
      gnt_o[i] = req_i[i] & ~blk;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, rst, rdy, alloc_i, occ_i};
  assign gnt_o  = req_i & (~req_i + 1'b1);
`endif
endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: free-list reservation station with CDB_N wakeup channels, dispatch bypass and one
// issue per cycle over valid/ready. Oldest-first select when RS_AGE_PRIO_EN is defined.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CDB_N  = 2,
  parameter int NICK_W = NICK_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  output logic                       oINF_full,
  output logic [$clog2(DEPTH+1)-1:0] oINF_cnt,
  input  logic                       iDP_en,
  input  logic [OP_W-1:0]            iDP_op,
  input  logic [ADDR_W-1:0]          iDP_pc,
  input  logic [IMM_W-1:0]           iDP_imm,
  input  logic [NICK_W-1:0]          iDP_rd_nick,
  input  logic [NICK_W-1:0]          iDP_rs1_nick,
  input  logic [NICK_W-1:0]          iDP_rs2_nick,
  input  logic [DATA_W-1:0]          iDP_rs1_dt,
  input  logic [DATA_W-1:0]          iDP_rs2_dt,
  input  logic [CDB_N-1:0]           iCDB_en,
  input  logic [CDB_N*NICK_W-1:0]    iCDB_nick,
  input  logic [CDB_N*DATA_W-1:0]    iCDB_dt,
  output logic                       oEX_en,
  input  logic                       iEX_ready,
  output logic [OP_W-1:0]            oEX_op,
  output logic [ADDR_W-1:0]          oEX_pc,
  output logic [IMM_W-1:0]           oEX_imm,
  output logic [NICK_W-1:0]          oEX_rd_nick,
  output logic [DATA_W-1:0]          oEX_rs1_dt,
  output logic [DATA_W-1:0]          oEX_rs2_dt
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [NICK_W-1:0] NICK_RDY = NICK_W'(NICK_READY);
  logic [DEPTH-1:0]  occ_q, v1_q, v2_q, free_oh, alloc, req, gnt, sel;
  logic [NICK_W-1:0] n1_q [DEPTH], n2_q [DEPTH], rd_q [DEPTH];
  logic [DATA_W-1:0] d1_q [DEPTH], d2_q [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [IMM_W-1:0]  imm_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic              ex_en_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [ADDR_W-1:0] ex_pc_q;
  logic [IMM_W-1:0]  ex_imm_q;
  logic [NICK_W-1:0] ex_rd_q;
  logic [DATA_W-1:0] ex_d1_q, ex_d2_q;
  logic [IDX_W-1:0]  sidx;
  logic              dp_acc, can_iss, any;
  function automatic logic hit(input logic [NICK_W-1:0] n);
    hit = 1'b0;
    for (int k = 0; k < CDB_N; k++)
      hit = hit | (iCDB_en[k] && n != NICK_RDY && iCDB_nick[k*NICK_W +: NICK_W] == n);
  endfunction
  // scanned high-to-low so the lowest matching channel wins
  function automatic logic [DATA_W-1:0] cdb_dt(input logic [NICK_W-1:0] n);
    cdb_dt = '0;
    for (int k = CDB_N-1; k >= 0; k--)
      if (iCDB_en[k] && iCDB_nick[k*NICK_W +: NICK_W] == n) cdb_dt = iCDB_dt[k*DATA_W +: DATA_W];
  endfunction
  assign oINF_full = cnt_q == CNT_W'(DEPTH);
  assign oINF_cnt  = cnt_q;
  assign dp_acc    = iDP_en && !oINF_full;
  assign free_oh   = ~occ_q & (occ_q + 1'b1);
  assign alloc     = (dp_acc && !clr) ? free_oh : '0;
  assign req       = occ_q & v1_q & v2_q;
  assign any       = |req;
  assign can_iss   = !ex_en_q || iEX_ready;
  assign sel       = (can_iss && !clr) ? gnt : '0;
  always_comb begin
    sidx = '0;
    for (int i = 0; i < DEPTH; i++) if (gnt[i]) sidx = IDX_W'(i);
  end
  rs_age_sel #(.DEPTH(DEPTH)) u_sel (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_i(alloc), .occ_i(occ_q), .req_i(req), .gnt_o(gnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      occ_q    <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      cnt_q    <= '0;
      ex_en_q  <= 1'b0;
      ex_op_q  <= '0;
      ex_pc_q  <= '0;
      ex_imm_q <= '0;
      ex_rd_q  <= '0;
      ex_d1_q  <= '0;
      ex_d2_q  <= '0;
    end else if (rdy) begin
      if (clr) begin
        occ_q   <= '0;
        cnt_q   <= '0;
        ex_en_q <= 1'b0;
      end else begin
        occ_q <= (occ_q & ~sel) | alloc;
        cnt_q <= cnt_q + CNT_W'(dp_acc) - CNT_W'(|sel);
        for (int i = 0; i < DEPTH; i++)
          if (alloc[i]) begin
            v1_q[i] <= iDP_rs1_nick == NICK_RDY || hit(iDP_rs1_nick);
            v2_q[i] <= iDP_rs2_nick == NICK_RDY || hit(iDP_rs2_nick);
          end else begin
            if (occ_q[i] && !v1_q[i] && hit(n1_q[i])) v1_q[i] <= 1'b1;
            if (occ_q[i] && !v2_q[i] && hit(n2_q[i])) v2_q[i] <= 1'b1;
          end
        if (can_iss) begin
          ex_en_q <= any;
          if (any) begin
            ex_op_q  <= op_q[sidx];
            ex_pc_q  <= pc_q[sidx];
            ex_imm_q <= imm_q[sidx];
            ex_rd_q  <= rd_q[sidx];
            ex_d1_q  <= d1_q[sidx];
            ex_d2_q  <= d2_q[sidx];
          end
        end
      end
    end
  // entry payload needs no reset: it is only read once occ/valid say so
  always_ff @(posedge clk)
    if (rdy && !clr)
      for (int i = 0; i < DEPTH; i++)
        if (alloc[i]) begin
          op_q[i]  <= iDP_op;
          pc_q[i]  <= iDP_pc;
          imm_q[i] <= iDP_imm;
          rd_q[i]  <= iDP_rd_nick;
          n1_q[i]  <= hit(iDP_rs1_nick) ? NICK_RDY : iDP_rs1_nick;
          n2_q[i]  <= hit(iDP_rs2_nick) ? NICK_RDY : iDP_rs2_nick;
          d1_q[i]  <= iDP_rs1_nick == NICK_RDY ? iDP_rs1_dt : cdb_dt(iDP_rs1_nick);
          d2_q[i]  <= iDP_rs2_nick == NICK_RDY ? iDP_rs2_dt : cdb_dt(iDP_rs2_nick);
        end else begin
          if (occ_q[i] && !v1_q[i] && hit(n1_q[i])) begin
            d1_q[i] <= cdb_dt(n1_q[i]);
            n1_q[i] <= NICK_RDY;
          end
          if (occ_q[i] && !v2_q[i] && hit(n2_q[i])) begin
            d2_q[i] <= cdb_dt(n2_q[i]);
            n2_q[i] <= NICK_RDY;
          end
        end
  assign oEX_en      = ex_en_q;
  assign oEX_op      = ex_op_q;
  assign oEX_pc      = ex_pc_q;
  assign oEX_imm     = ex_imm_q;
  assign oEX_rd_nick = ex_rd_q;
  assign oEX_rs1_dt  = ex_d1_q;
  assign oEX_rs2_dt  = ex_d2_q;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb: directed + random stimulus against an entry-list model of the RS with a per-cycle compare.
module tb_rs_multi_cdb;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
  logic oINF_full;
  logic [4:0] oINF_cnt;
  logic iDP_en = 1'b0;
  logic [5:0] iDP_op = '0;
  logic [31:0] iDP_pc = '0, iDP_imm = '0, iDP_rs1_dt = '0, iDP_rs2_dt = '0;
  logic [4:0] iDP_rd_nick = '0, iDP_rs1_nick = '0, iDP_rs2_nick = '0;
  logic [1:0] iCDB_en = '0;
  logic [9:0] iCDB_nick = '0;
  logic [63:0] iCDB_dt = '0;
  logic oEX_en, iEX_ready = 1'b1;
  logic [5:0] oEX_op;
  logic [31:0] oEX_pc, oEX_imm, oEX_rs1_dt, oEX_rs2_dt;
  logic [4:0] oEX_rd_nick;
  int n_cmp = 0, n_err = 0;
  bit run = 1'b0;

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .oINF_full(oINF_full), .oINF_cnt(oINF_cnt),
    .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_pc(iDP_pc), .iDP_imm(iDP_imm), .iDP_rd_nick(iDP_rd_nick),
    .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
    .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt), .oEX_en(oEX_en), .iEX_ready(iEX_ready),
    .oEX_op(oEX_op), .oEX_pc(oEX_pc), .oEX_imm(oEX_imm), .oEX_rd_nick(oEX_rd_nick),
    .oEX_rs1_dt(oEX_rs1_dt), .oEX_rs2_dt(oEX_rs2_dt)
  );

  always #5 clk = ~clk;

  // model: list of entries with an allocation sequence number standing in for age
  bit          m_occ [D];
  bit          m_v1 [D], m_v2 [D];
  int          m_seq [D];
  logic [4:0]  m_n1 [D], m_n2 [D], m_rd [D];
  logic [31:0] m_d1 [D], m_d2 [D], m_pc [D], m_imm [D];
  logic [5:0]  m_op [D];
  bit          m_ex_en;
  logic [5:0]  m_ex_op;
  logic [31:0] m_ex_pc, m_ex_imm, m_ex_d1, m_ex_d2;
  logic [4:0]  m_ex_rd;
  int          seq_ctr;

  function automatic int m_cnt();
    m_cnt = 0;
    for (int i = 0; i < D; i++) m_cnt += int'(m_occ[i]);
  endfunction

  function automatic bit m_look(input logic [4:0] n, output logic [31:0] d);
    m_look = 1'b0;
    d = '0;
    for (int k = 0; k < 2; k++)
      if (!m_look && n != 0 && iCDB_en[k] && iCDB_nick[k*5 +: 5] == n) begin
        m_look = 1'b1;
        d = iCDB_dt[k*32 +: 32];
      end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_occ[i] = 0; m_v1[i] = 0; m_v2[i] = 0;
    end
    m_ex_en = 0; m_ex_op = '0; m_ex_pc = '0; m_ex_imm = '0; m_ex_rd = '0; m_ex_d1 = '0; m_ex_d2 = '0;
    seq_ctr = 0;
  endtask

  // predicts the state after the coming rising edge from the inputs now applied
  task automatic model_step();
    int cnt, s, f;
    logic [31:0] d;
    if (!rst || !rdy) return;
    if (clr) begin
      for (int i = 0; i < D; i++) m_occ[i] = 0;
      m_ex_en = 0;
      return;
    end
    cnt = m_cnt();
    s = -1;
    f = -1;
    for (int i = 0; i < D; i++) begin
      if (f < 0 && !m_occ[i]) f = i;
      if (m_occ[i] && m_v1[i] && m_v2[i]) begin
`ifdef RS_AGE_PRIO_EN
        if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    if (!m_ex_en || iEX_ready) begin
      m_ex_en = s >= 0;
      if (s >= 0) begin
        m_ex_op = m_op[s]; m_ex_pc = m_pc[s]; m_ex_imm = m_imm[s]; m_ex_rd = m_rd[s];
        m_ex_d1 = m_d1[s]; m_ex_d2 = m_d2[s];
        m_occ[s] = 0;
      end
    end
    for (int i = 0; i < D; i++) if (m_occ[i]) begin
      if (!m_v1[i] && m_look(m_n1[i], d)) begin m_v1[i] = 1; m_d1[i] = d; end
      if (!m_v2[i] && m_look(m_n2[i], d)) begin m_v2[i] = 1; m_d2[i] = d; end
    end
    if (iDP_en && cnt < D) begin
      m_occ[f] = 1; m_seq[f] = seq_ctr++;
      m_op[f] = iDP_op; m_pc[f] = iDP_pc; m_imm[f] = iDP_imm; m_rd[f] = iDP_rd_nick;
      m_n1[f] = iDP_rs1_nick; m_n2[f] = iDP_rs2_nick;
      m_v1[f] = iDP_rs1_nick == 0 || m_look(iDP_rs1_nick, d);
      m_d1[f] = iDP_rs1_nick == 0 ? iDP_rs1_dt : d;
      m_v2[f] = iDP_rs2_nick == 0 || m_look(iDP_rs2_nick, d);
      m_d2[f] = iDP_rs2_nick == 0 ? iDP_rs2_dt : d;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("cnt", 64'(oINF_cnt), 64'(m_cnt()));
    chk("full", 64'(oINF_full), 64'(m_cnt() == D));
    chk("ex_en", 64'(oEX_en), 64'(m_ex_en));
    chk("ex_op", 64'(oEX_op), 64'(m_ex_op));
    chk("ex_pc", 64'(oEX_pc), 64'(m_ex_pc));
    chk("ex_imm", 64'(oEX_imm), 64'(m_ex_imm));
    chk("ex_rd", 64'(oEX_rd_nick), 64'(m_ex_rd));
    chk("ex_rs1", 64'(oEX_rs1_dt), 64'(m_ex_d1));
    chk("ex_rs2", 64'(oEX_rs2_dt), 64'(m_ex_d2));
  end

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    iDP_en = 0; iCDB_en = '0; clr = 0; rdy = 1; iEX_ready = 1;
  endtask

  task automatic dp(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] n1, input logic [31:0] d1,
                    input logic [4:0] n2, input logic [31:0] d2);
    iDP_en = 1; iDP_op = op; iDP_pc = pc; iDP_imm = ~pc; iDP_rd_nick = pc[4:0];
    iDP_rs1_nick = n1; iDP_rs1_dt = d1; iDP_rs2_nick = n2; iDP_rs2_dt = d2;
  endtask

  task automatic cdb(input int k, input logic [4:0] n, input logic [31:0] dt);
    iCDB_en[k] = 1'b1; iCDB_nick[k*5 +: 5] = n; iCDB_dt[k*32 +: 32] = dt;
  endtask

  initial begin
    #1 rst = 0;
    model_reset();
    @(negedge clk); #1;
    run = 1;
    chk("rst_cnt", 64'(oINF_cnt), 64'd0);
    chk("rst_en", 64'(oEX_en), 64'd0);
    chk("rst_rs1", 64'(oEX_rs1_dt), 64'd0);
    rst = 1;
    step();
    // ready op issues one edge after dispatch
    dp(3, 32'h100, 0, 5, 0, 7); step(); idle();
    chk("t1_en_early", 64'(oEX_en), 64'd0);
    chk("t1_cnt1", 64'(oINF_cnt), 64'd1);
    step();
    chk("t1_en", 64'(oEX_en), 64'd1);
    chk("t1_rs1", 64'(oEX_rs1_dt), 64'd5);
    chk("t1_rs2", 64'(oEX_rs2_dt), 64'd7);
    chk("t1_cnt0", 64'(oINF_cnt), 64'd0);
    step();
    chk("t1_drop", 64'(oEX_en), 64'd0);
    // wakeup two cycles after dispatch
    dp(1, 32'h200, 3, 0, 0, 1); step(); idle(); step(); step();
    cdb(0, 3, 32'hAB); step(); idle();
    chk("t2_wait", 64'(oEX_en), 64'd0);
    step();
    chk("t2_en", 64'(oEX_en), 64'd1);
    chk("t2_rs1", 64'(oEX_rs1_dt), 64'hAB);
    step();
    // bypass: broadcast in the dispatch cycle
    dp(2, 32'h300, 3, 0, 0, 2); cdb(0, 3, 32'hCD); step(); idle();
    chk("t2b_wait", 64'(oEX_en), 64'd0);
    step();
    chk("t2b_en", 64'(oEX_en), 64'd1);
    chk("t2b_rs1", 64'(oEX_rs1_dt), 64'hCD);
    step();
    // fill, extra dispatch ignored, then drain DEPTH issues
    for (int i = 0; i < D; i++) begin dp(4, 32'h400 + i, 9, 0, 0, i); step(); end
    idle();
    chk("t3_full", 64'(oINF_full), 64'd1);
    dp(5, 32'h500, 0, 32'h77, 0, 32'h77); step(); idle();
    chk("t3_cnt", 64'(oINF_cnt), 64'(D));
    cdb(1, 9, 32'h999); cdb(0, 10, 32'h555); step(); idle();
    chk("t3_noiss", 64'(oEX_en), 64'd0);
    for (int i = 0; i < D; i++) begin
      step();
      chk("t3_en", 64'(oEX_en), 64'd1);
      chk("t3_pc", 64'(oEX_pc), 64'(32'h400 + i));
      chk("t3_rs1", 64'(oEX_rs1_dt), 64'h999);
      chk("t3_cnt_dn", 64'(oINF_cnt), 64'(D - 1 - i));
      chk("t3_fulldn", 64'(oINF_full), 64'd0);
    end
    step();
    chk("t3_end", 64'(oEX_en), 64'd0);
    // back-pressure holds the issue register
    iEX_ready = 0;
    dp(6, 32'h600, 0, 32'h11, 0, 0); step();
    dp(6, 32'h601, 0, 32'h22, 0, 0); step(); idle(); iEX_ready = 0;
    repeat (4) begin
      step();
      chk("t4_hold_en", 64'(oEX_en), 64'd1);
      chk("t4_hold_rs1", 64'(oEX_rs1_dt), 64'h11);
    end
    iEX_ready = 1; step();
    chk("t4_next", 64'(oEX_rs1_dt), 64'h22);
    step();
    // age vs index priority
    dp(7, 32'hA00, 5, 0, 0, 0); step();
    dp(7, 32'hB00, 6, 0, 0, 0); step(); idle();
    cdb(0, 5, 32'h55); step(); idle(); step();
    chk("t5_a", 64'(oEX_pc), 64'hA00);
    dp(7, 32'hC00, 6, 0, 0, 0); step(); idle();
    cdb(0, 6, 32'h66); step(); idle();
    step();
`ifdef RS_AGE_PRIO_EN
    chk("t5_first", 64'(oEX_pc), 64'hB00);
    step();
    chk("t5_second", 64'(oEX_pc), 64'hC00);
`else
    chk("t5_first", 64'(oEX_pc), 64'hC00);
    step();
    chk("t5_second", 64'(oEX_pc), 64'hB00);
`endif
    step();
    // clr with 5 entries and a held issue; same-cycle dispatch dropped
    iEX_ready = 0;
    dp(8, 32'hD00, 0, 1, 0, 1); step();
    for (int i = 0; i < 5; i++) begin dp(8, 32'hD10 + i, 7, 0, 0, 0); step(); end
    idle(); iEX_ready = 0;
    chk("t6_cnt5", 64'(oINF_cnt), 64'd5);
    dp(8, 32'hD20, 0, 0, 0, 0); cdb(0, 7, 32'h7); clr = 1; step(); idle();
    chk("t6_en", 64'(oEX_en), 64'd0);
    chk("t6_cnt", 64'(oINF_cnt), 64'd0);
    chk("t6_pc_held", 64'(oEX_pc), 64'hD00);
    step();
    // async reset mid-stream
    iEX_ready = 0;
    dp(9, 32'hE00, 0, 3, 0, 3); step();
    dp(9, 32'hE01, 0, 3, 0, 3); step(); idle(); iEX_ready = 0;
    chk("t7_pre", 64'(oEX_en), 64'd1);
    rst = 0; model_reset(); #1;
    chk("t7_en", 64'(oEX_en), 64'd0);
    chk("t7_cnt", 64'(oINF_cnt), 64'd0);
    chk("t7_pc", 64'(oEX_pc), 64'd0);
    rst = 1; idle();
    step();
    // random traffic
    repeat (3000) begin
      iDP_en = $urandom_range(0, 99) < 60;
      iDP_op = 6'($urandom); iDP_pc = $urandom; iDP_imm = $urandom; iDP_rd_nick = 5'($urandom);
      iDP_rs1_nick = $urandom_range(0, 99) < 40 ? 5'd0 : 5'($urandom_range(1, 7));
      iDP_rs2_nick = $urandom_range(0, 99) < 50 ? 5'd0 : 5'($urandom_range(1, 7));
      iDP_rs1_dt = $urandom; iDP_rs2_dt = $urandom;
      iCDB_en = 2'($urandom);
      iCDB_nick = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iCDB_dt = {$urandom, $urandom};
      iEX_ready = $urandom_range(0, 99) < 75;
      rdy = $urandom_range(0, 99) < 92;
      clr = $urandom_range(0, 99) < 2;
      step();
    end
    idle();
    repeat (D + 4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
